// File: rtl/serial_word_transmitter.sv
// serial_word_transmitter
//   Parallel-in/serial-out stage that feeds a downstream serial-in shift register.
//   It accepts one word per valid/ready handshake and then drives the word onto data_out_o,
//   one bit per clock, with bit_valid_o high for each frame bit.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_GAP   idle cycles forced between frames (0..15)
//
// Optional feature
//   PARITY_EN  when defined, one even-parity bit follows the data bits. That bit is the last
//              frame cycle.
//
// Ports
//   clk_i        rising-edge clock
//   reset_ni     synchronous active-low reset
//   tx_data_i    word to send; sampled only on acceptance
//   tx_valid_i   tx_data_i is valid
//   tx_ready_o   block can accept; handshake = tx_valid_i & tx_ready_o at a rising edge
//   data_out_o   serial bit to the downstream register
//   bit_valid_o  data_out_o carries a frame bit this cycle
//   busy_o       frame or gap in progress
//   word_done_o  1-cycle pulse during the last frame cycle
module serial_word_transmitter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDLE_GAP  = 0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             data_out_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             word_done_o
);

  localparam int unsigned       CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]   LastIdx = CntW'(WIDTH - 1);
  // The gap counter counts down to zero, so load it with one less than the gap length.
  localparam logic [3:0]        GapLoad = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

`ifdef PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [3:0]        gap_q, gap_d;
  logic              data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              last_cycle;
  logic              accept;
  logic [CntW-1:0]   bit_idx;

  always_comb begin
    last_cycle = ((state_q == StShift) && (cnt_q == LastIdx) && !ParityEn) ||
                 (state_q == StParity);
    // Ready is gated by the raw reset input so no handshake can happen during reset.
    tx_ready_o = reset_ni && ((state_q == StIdle) || (last_cycle && (IDLE_GAP == 0)));
    accept     = tx_valid_i && tx_ready_o;

    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    gap_d   = gap_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = '0;
          word_d  = tx_data_i;
        end
      end
      StShift: begin
        if (cnt_q != LastIdx) begin
          cnt_d = cnt_q + 1'b1;
        end else if (ParityEn) begin
          state_d = StParity;
        end
      end
      StParity: ;
      StGap: begin
        if (gap_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame exit: either chain straight into the next word, drop to idle, or start the gap.
    if (last_cycle) begin
      if (IDLE_GAP == 0) begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = '0;
          word_d  = tx_data_i;
        end else begin
          state_d = StIdle;
        end
      end else begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
    end

    // Outputs are registered, so derive them from the state being entered.
    bit_idx = MSB_FIRST ? (LastIdx - cnt_d) : cnt_d;
    valid_d = (state_d == StShift) || (state_d == StParity);
    busy_d  = (state_d != StIdle);
    data_d  = 1'b0;
    if (state_d == StShift) begin
      data_d = word_d[bit_idx];
    end else if (state_d == StParity) begin
      data_d = ^word_d;
    end
    done_d = ((state_d == StShift) && (cnt_d == LastIdx) && !ParityEn) ||
             (state_d == StParity);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      gap_q   <= 4'd0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out_o  = data_q;
  assign bit_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign word_done_o = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter. Three instances share clock, reset and the test sequence:
//   0: MSB first, no gap   1: MSB first, gap of 2   2: LSB first, no gap
// A queue-based timeline model predicts every output per cycle. Receiver models rebuild the
// words from the serial stream so they can be checked against hand-written values.
module tb_serial_word_transmitter;

  localparam int N = 3;
  localparam bit          MSB [N] = '{1'b1, 1'b1, 1'b0};
  localparam int unsigned GAP [N] = '{0, 2, 0};
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct packed {
    logic d;  // data_out
    logic v;  // bit_valid
    logic b;  // busy
    logic k;  // word_done
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data  [N];
  logic       tx_valid [N];
  logic       ready    [N];
  logic       dout     [N];
  logic       bval     [N];
  logic       busy     [N];
  logic       done     [N];

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  ent_t       mq   [N][$];
  logic [7:0] cap  [N][$];
  logic       parl [$];
  logic [7:0] rx   [N];
  int         rx_n [N];
  int         run_cur [N];
  int         run_max [N];
  int         gap_cnt [N];
  int         done_cnt[N];

  always #5 clk = ~clk;

  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(0)) u_dut0 (
    .clk_i(clk), .reset_ni(rst_n), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(ready[0]), .data_out_o(dout[0]), .bit_valid_o(bval[0]), .busy_o(busy[0]),
    .word_done_o(done[0]));

  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(2)) u_dut1 (
    .clk_i(clk), .reset_ni(rst_n), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(ready[1]), .data_out_o(dout[1]), .bit_valid_o(bval[1]), .busy_o(busy[1]),
    .word_done_o(done[1]));

  serial_word_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_GAP(0)) u_dut2 (
    .clk_i(clk), .reset_ni(rst_n), .tx_data_i(tx_data[2]), .tx_valid_i(tx_valid[2]),
    .tx_ready_o(ready[2]), .data_out_o(dout[2]), .bit_valid_o(bval[2]), .busy_o(busy[2]),
    .word_done_o(done[2]));

  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %b, expected %b", nm, k, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Ready may be high when idle, or (gap-free only) during the last remaining frame cycle.
  function automatic logic exp_ready(input int k);
    return rst_n && ((mq[k].size() == 0) || ((GAP[k] == 0) && (mq[k].size() == 1)));
  endfunction

  function automatic void push_frame(input int k, input logic [7:0] w);
    ent_t e;
    for (int i = 0; i < 8; i++) begin
      e.d = MSB[k] ? w[3'(7 - i)] : w[3'(i)];
      e.v = 1'b1;
      e.b = 1'b1;
      e.k = (i == 7) && !PAR;
      mq[k].push_back(e);
    end
    if (PAR) begin
      e = '{d: ^w, v: 1'b1, b: 1'b1, k: 1'b1};
      mq[k].push_back(e);
    end
    for (int g = 0; g < int'(GAP[k]); g++) begin
      e = '{d: 1'b0, v: 1'b0, b: 1'b1, k: 1'b0};
      mq[k].push_back(e);
    end
  endfunction

  // Model timeline: head of each queue is the current cycle's expected outputs.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic hs;
      hs = tx_valid[k] && exp_ready(k);
      if (!rst_n) begin
        mq[k].delete();
      end else begin
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        if (hs) push_frame(k, tx_data[k]);
      end
    end
  end

  // Compare process plus receiver models, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < N; k++) begin
        ent_t e;
        e = (mq[k].size() > 0) ? mq[k][0] : '0;
        chk("tx_ready",  k, ready[k], exp_ready(k));
        chk("data_out",  k, dout[k],  e.d);
        chk("bit_valid", k, bval[k],  e.v);
        chk("busy",      k, busy[k],  e.b);
        chk("word_done", k, done[k],  e.k);

        if (bval[k] && rx_n[k] < 8) begin
          rx[k] = MSB[k] ? {rx[k][6:0], dout[k]} : {dout[k], rx[k][7:1]};
          rx_n[k]++;
        end
        if (done[k]) begin
          cap[k].push_back(rx[k]);
          if (PAR && k == 0) parl.push_back(dout[k]);
          rx_n[k] = 0;
          done_cnt[k]++;
        end
        if (!rst_n) rx_n[k] = 0;

        run_cur[k] = bval[k] ? run_cur[k] + 1 : 0;
        if (run_cur[k] > run_max[k]) run_max[k] = run_cur[k];
        if (rst_n && !bval[k] && !ready[k]) gap_cnt[k]++;
      end
    end
  end

  // Present a word with valid high and return just after the accepting edge.
  task automatic send_word(input int k, input logic [7:0] w);
    int t;
    t = 0;
    tx_data[k]  = w;
    tx_valid[k] = 1'b1;
    @(negedge clk);
    while (!ready[k] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk_int($sformatf("handshake_bound[%0d]", k), int'(t < 40), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int k, input logic [7:0] w);
    send_word(k, w);
    tx_valid[k] = 1'b0;
  endtask

  task automatic send_pair(input int k, input logic [7:0] a, input logic [7:0] b);
    send_word(k, a);
    send_word(k, b);
    tx_valid[k] = 1'b0;
  endtask

  task automatic send_all(input logic [7:0] w);
    fork
      send_one(0, w);
      send_one(1, w);
      send_one(2, w);
    join
  endtask

  task automatic settle();
    repeat (16) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_words [$];
    int frames;

    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      tx_data[k]  = 8'h00;
      tx_valid[k] = 1'b0;
      rx[k]       = 8'h00;
      rx_n[k]     = 0;
      run_cur[k]  = 0;
      run_max[k]  = 0;
      gap_cnt[k]  = 0;
      done_cnt[k] = 0;
    end
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  0, busy[0],  1'b0);
    chk("reset_valid", 0, bval[0],  1'b0);
    chk("reset_ready", 0, ready[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, then back-to-back pair with valid held.
    send_all(8'hA5);
    settle();
    fork
      send_pair(0, 8'h3C, 8'hC3);
      send_pair(1, 8'h3C, 8'hC3);
      send_pair(2, 8'h3C, 8'hC3);
    join
    settle();

    // Reset during the 4th bit of 8'hFF abandons the word.
    send_all(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_valid", 0, bval[0], 1'b0);
    chk("midreset_data",  0, dout[0], 1'b0);
    chk("midreset_done",  0, done[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_all(8'h01);
    settle();

    // tx_valid/tx_data wiggling mid-frame must be ignored.
    send_all(8'h80);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < N; k++) begin
        tx_data[k]  = 8'hFF;
        tx_valid[k] = ~tx_valid[k];
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < N; k++) tx_valid[k] = 1'b0;
    settle();

    exp_words = '{8'hA5, 8'h3C, 8'hC3, 8'h01, 8'h80};
`ifdef PARITY_EN
    send_all(8'h07);
    settle();
    send_all(8'h03);
    settle();
    exp_words.push_back(8'h07);
    exp_words.push_back(8'h03);
    chk_int("parity_count", parl.size(), 7);
    if (parl.size() == 7) begin
      chk("parity_07", 0, parl[5], 1'b1);
      chk("parity_03", 0, parl[6], 1'b0);
    end
`endif
    frames = exp_words.size();

    for (int k = 0; k < N; k++) begin
      chk_int($sformatf("words_received[%0d]", k), cap[k].size(), frames);
      chk_int($sformatf("word_done_count[%0d]", k), done_cnt[k], frames);
      for (int i = 0; i < frames && i < cap[k].size(); i++) begin
        chk_int($sformatf("rx_word[%0d][%0d]", k, i), int'(cap[k][i]), int'(exp_words[i]));
      end
    end
    chk_int("b2b_run_nogap", run_max[0], PAR ? 18 : 16);
    chk_int("run_with_gap",  run_max[1], PAR ? 9 : 8);
    chk_int("gap_cycles",    gap_cnt[1], 2 * frames);
    chk_int("gap_cycles_nogap_inst", gap_cnt[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
